stats_accum_unit: RTL and testbench



---
 rtl/stats_accum_unit.sv | 149 ++++++++++++++
 tb/tb_stats_accum_unit.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/stats_accum_unit.sv
// Running MAX/MIN/SUM over N unsigned samples, then AVG = floor(SUM/N)
// via a one-bit-per-cycle restoring divider.
module stats_accum_unit #(
    parameter int DATA_W = 8,
    parameter int SUM_W  = 16
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              Load_COUNT_R,
    input  logic              Sample_VALID,
    input  logic [DATA_W-1:0] BUS_DATA,
    output logic [DATA_W-1:0] MAX_value,
    output logic [DATA_W-1:0] MIN_value,
    output logic [SUM_W-1:0]  SUM_value,
    output logic [DATA_W-1:0] AVG_value,
    output logic              AVG_done,
    output logic              Count_zero,
    output logic              Sign_value,
    output logic              Busy
);

    typedef enum logic [1:0] {IDLE, ACCUM, DIVIDE} state_t;
    localparam int IW = $clog2(SUM_W);

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0]  div_q, div_d;
    logic [SUM_W-1:0]   sum_q, sum_d;
    logic [DATA_W-1:0]  max_q, max_d;
    logic [DATA_W-1:0]  min_q, min_d;
    logic [DATA_W-1:0]  avg_q, avg_d;
    logic               sign_q, sign_d;
    logic               done_q, done_d;
    logic [SUM_W-1:0]   quo_q, quo_d;
    logic [DATA_W-1:0]  rem_q, rem_d;
    logic [IW-1:0]      iter_q, iter_d;

    logic [DATA_W:0]    trial;
    logic               fits;
    logic [SUM_W-1:0]   quo_shift;
    logic [SUM_W-1:0]   sum_add;

    // Dividend bits shift out of quo_q's top while quotient bits enter below.
    assign trial     = {rem_q, quo_q[SUM_W-1]};
    assign fits      = trial >= {1'b0, div_q};
    assign quo_shift = {quo_q[SUM_W-2:0], fits};
    assign sum_add   = sum_q + {{(SUM_W-DATA_W){1'b0}}, BUS_DATA};

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        div_d   = div_q;
        sum_d   = sum_q;
        max_d   = max_q;
        min_d   = min_q;
        avg_d   = avg_q;
        sign_d  = sign_q;
        done_d  = 1'b0;
        quo_d   = quo_q;
        rem_d   = rem_q;
        iter_d  = iter_q;
        if (Load_COUNT_R) begin
            count_d = BUS_DATA;
            div_d   = BUS_DATA;
            sum_d   = '0;
            max_d   = '0;
            min_d   = '1;
            sign_d  = 1'b0;
            iter_d  = '0;
            if (BUS_DATA != '0) begin
                state_d = ACCUM;
            end else begin
                state_d = IDLE;
                avg_d   = '0;
                done_d  = 1'b1;
            end
        end else begin
            unique case (state_q)
                ACCUM: begin
                    if (Sample_VALID) begin
                        sum_d   = sum_add;
                        max_d   = (BUS_DATA > max_q) ? BUS_DATA : max_q;
                        min_d   = (BUS_DATA < min_q) ? BUS_DATA : min_q;
                        sign_d  = BUS_DATA < max_q;
                        count_d = count_q - DATA_W'(1);
                        if (count_q == DATA_W'(1)) begin
                            state_d = DIVIDE;
                            quo_d   = sum_add;
                            rem_d   = '0;
                            iter_d  = '0;
                        end
                    end
                end
                DIVIDE: begin
                    rem_d  = fits ? DATA_W'(trial - {1'b0, div_q})
                                  : trial[DATA_W-1:0];
                    quo_d  = quo_shift;
                    iter_d = iter_q + IW'(1);
                    if (iter_q == IW'(SUM_W-1)) begin
                        avg_d   = quo_shift[DATA_W-1:0];
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            count_q <= '0;
            div_q   <= '0;
            sum_q   <= '0;
            max_q   <= '0;
            min_q   <= '1;
            avg_q   <= '0;
            sign_q  <= 1'b0;
            done_q  <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
            iter_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            div_q   <= div_d;
            sum_q   <= sum_d;
            max_q   <= max_d;
            min_q   <= min_d;
            avg_q   <= avg_d;
            sign_q  <= sign_d;
            done_q  <= done_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            iter_q  <= iter_d;
        end
    end

    assign MAX_value  = max_q;
    assign MIN_value  = min_q;
    assign SUM_value  = sum_q;
    assign AVG_value  = avg_q;
    assign AVG_done   = done_q;
    assign Count_zero = (count_q == '0);
    assign Sign_value = sign_q;
    assign Busy       = (state_q != IDLE);

endmodule

// File: tb/tb_stats_accum_unit.sv
// Directed bench for stats_accum_unit: accumulate, divide, load-abort,
// zero-count and mid-run reset cases against hand-computed values.
module tb_stats_accum_unit;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        Load_COUNT_R = 1'b0;
    logic        Sample_VALID = 1'b0;
    logic [7:0]  BUS_DATA = '0;
    logic [7:0]  MAX_value, MIN_value, AVG_value;
    logic [15:0] SUM_value;
    logic        AVG_done, Count_zero, Sign_value, Busy;

    int vectors = 0;
    int miscompares = 0;
    int done_cnt = 0;

    stats_accum_unit dut (
        .CLK(CLK),
        .RESET(RESET),
        .Load_COUNT_R(Load_COUNT_R),
        .Sample_VALID(Sample_VALID),
        .BUS_DATA(BUS_DATA),
        .MAX_value(MAX_value),
        .MIN_value(MIN_value),
        .SUM_value(SUM_value),
        .AVG_value(AVG_value),
        .AVG_done(AVG_done),
        .Count_zero(Count_zero),
        .Sign_value(Sign_value),
        .Busy(Busy)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK)
        if (AVG_done === 1'b1) done_cnt <= done_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic load(input logic [7:0] n);
        Load_COUNT_R = 1'b1;
        BUS_DATA = n;
        tick();
        Load_COUNT_R = 1'b0;
    endtask

    task automatic sample(input logic [7:0] s);
        Sample_VALID = 1'b1;
        BUS_DATA = s;
        tick();
        Sample_VALID = 1'b0;
    endtask

    // Returns edges elapsed until AVG_done is seen, bounded.
    task automatic wait_done(output int cnt);
        cnt = 0;
        while (AVG_done !== 1'b1 && cnt < 40) begin
            tick();
            cnt++;
        end
    endtask

    logic [7:0] s2 [4] = '{8'd10, 8'd200, 8'd3, 8'd7};
    logic       g2 [4] = '{1'b0, 1'b0, 1'b1, 1'b1};

    initial begin
        int lat;
        int base;

        // 1: reset
        tick(2);
        RESET = 1'b0;
        chk("rst_max", MAX_value, 0);
        chk("rst_min", MIN_value, 8'hFF);
        chk("rst_sum", SUM_value, 0);
        chk("rst_avg", AVG_value, 0);
        chk("rst_cz", Count_zero, 1);
        chk("rst_busy", Busy, 0);
        chk("rst_done", AVG_done, 0);

        // 2: four samples back-to-back
        load(8'd4);
        chk("t2_busy", Busy, 1);
        chk("t2_cz0", Count_zero, 0);
        foreach (s2[i]) begin
            Sample_VALID = 1'b1;
            BUS_DATA = s2[i];
            tick();
            chk("t2_sign", Sign_value, g2[i]);
        end
        Sample_VALID = 1'b0;
        chk("t2_max", MAX_value, 200);
        chk("t2_min", MIN_value, 3);
        chk("t2_sum", SUM_value, 220);
        chk("t2_cz", Count_zero, 1);
        chk("t2_busy_div", Busy, 1);
        wait_done(lat);
        chk("t2_lat", lat, 16);
        chk("t2_avg", AVG_value, 55);
        chk("t2_busy_end", Busy, 0);
        tick();
        chk("t2_done_pulse", AVG_done, 0);

        // 3: 255 samples of 0xFF with gaps
        base = done_cnt;
        load(8'd255);
        for (int i = 0; i < 255; i++) begin
            tick($urandom_range(0, 2));
            sample(8'hFF);
        end
        chk("t3_sum", SUM_value, 65025);
        chk("t3_max", MAX_value, 255);
        chk("t3_min", MIN_value, 255);
        chk("t3_cz", Count_zero, 1);
        wait_done(lat);
        chk("t3_lat", lat, 16);
        chk("t3_avg", AVG_value, 255);
        tick(4);
        chk("t3_ndone", done_cnt - base, 1);

        // 4: zero count
        load(8'd0);
        chk("t4_done", AVG_done, 1);
        chk("t4_avg", AVG_value, 0);
        chk("t4_cz", Count_zero, 1);
        chk("t4_busy", Busy, 0);
        tick();
        chk("t4_done_off", AVG_done, 0);

        // 5: reload during divide aborts it
        base = done_cnt;
        load(8'd3);
        sample(8'd9);
        sample(8'd9);
        sample(8'd9);
        chk("t5_sum27", SUM_value, 27);
        tick(4);
        Sample_VALID = 1'b1;
        load(8'd2);
        Sample_VALID = 1'b0;
        chk("t5_sum0", SUM_value, 0);
        chk("t5_max0", MAX_value, 0);
        chk("t5_min", MIN_value, 8'hFF);
        chk("t5_cz", Count_zero, 0);
        chk("t5_busy", Busy, 1);
        sample(8'd4);
        sample(8'd5);
        chk("t5_sum9", SUM_value, 9);
        wait_done(lat);
        chk("t5_lat", lat, 16);
        chk("t5_avg", AVG_value, 4);
        tick(2);
        chk("t5_ndone", done_cnt - base, 1);

        // 6: reset mid-run
        base = done_cnt;
        load(8'd5);
        sample(8'd1);
        sample(8'd2);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        chk("t6_max", MAX_value, 0);
        chk("t6_min", MIN_value, 8'hFF);
        chk("t6_sum", SUM_value, 0);
        chk("t6_avg", AVG_value, 0);
        chk("t6_cz", Count_zero, 1);
        chk("t6_busy", Busy, 0);
        tick(20);
        chk("t6_ndone", done_cnt - base, 0);
        load(8'd1);
        sample(8'd77);
        chk("t6_max77", MAX_value, 77);
        chk("t6_cz1", Count_zero, 1);
        wait_done(lat);
        chk("t6_lat", lat, 16);
        chk("t6_avg", AVG_value, 77);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
